// File: rtl/nco_hop_ctrl.sv
// Frequency-hop sequencer for an NCO. It walks a 4-entry FCW/dwell table,
// masks the NCO pipeline flush after each FCW change, and forwards valid samples.
module nco_hop_ctrl #(
  parameter int SETTLE  = 9,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               CfgWe,
  input  logic [1:0]         CfgAddr,
  input  logic [19:0]        CfgFCW,
  input  logic [DWELL_W-1:0] CfgDwell,
  input  logic [1:0]         NumHops,
  input  logic               Loop,
  input  logic               SelXYCfg,
  input  logic               SelSignCfg,
  input  logic               Start,
  input  logic               Stop,
  output logic               En,
  output logic [19:0]        FCW,
  output logic               selXY,
  output logic               selSign,
  input  logic               Vld,
  input  logic [11:0]        Dout,
  output logic               SampleVld,
  output logic [11:0]        Sample,
  output logic [1:0]         HopIdx,
  output logic               Busy,
  output logic               Done,
  output logic               CfgErr
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [19:0]        r_tbl_fcw   [4];
  logic [DWELL_W-1:0] r_tbl_dwell [4];

  logic               w_busy;
  logic [DWELL_W-1:0] w_dwell_eff;
  logic               w_dwell_last;
  logic               w_has_next;
  logic [1:0]         w_next_idx;

  // A programmed dwell of zero is treated as a single sample.
  assign w_busy       = (r_state == S_SETTLE) || (r_state == S_RUN);
  assign w_dwell_eff  = (r_tbl_dwell[HopIdx] == '0) ? DWELL_W'(1) : r_tbl_dwell[HopIdx];
  assign w_dwell_last = (r_dwell_cnt >= (w_dwell_eff - DWELL_W'(1)));
  assign w_has_next   = (HopIdx < NumHops) || Loop;
  assign w_next_idx   = (HopIdx < NumHops) ? (HopIdx + 2'd1) : 2'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_dwell_cnt  <= '0;
      for (int i = 0; i < 4; i++) begin
        r_tbl_fcw[i]   <= '0;
        r_tbl_dwell[i] <= '0;
      end
      En        <= 1'b0;
      FCW       <= '0;
      selXY     <= 1'b0;
      selSign   <= 1'b0;
      SampleVld <= 1'b0;
      Sample    <= '0;
      HopIdx    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      CfgErr    <= 1'b0;
    end else begin
      CfgErr    <= CfgWe && w_busy;
      SampleVld <= 1'b0;
      Done      <= 1'b0;
      if (CfgWe && !w_busy) begin
        r_tbl_fcw[CfgAddr]   <= CfgFCW;
        r_tbl_dwell[CfgAddr] <= CfgDwell;
      end

      if (Stop) begin
        r_state      <= S_IDLE;
        r_settle_cnt <= '0;
        r_dwell_cnt  <= '0;
        En           <= 1'b0;
        Busy         <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              r_state      <= S_SETTLE;
              r_settle_cnt <= SET_W'(SETTLE - 1);
              r_dwell_cnt  <= '0;
              HopIdx       <= 2'd0;
              FCW          <= r_tbl_fcw[0];
              selXY        <= SelXYCfg;
              selSign      <= SelSignCfg;
              En           <= 1'b1;
              Busy         <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (r_settle_cnt == '0) r_state <= S_RUN;
            else r_settle_cnt <= r_settle_cnt - SET_W'(1);
          end
          S_RUN: begin
            if (Vld) begin
              SampleVld <= 1'b1;
              Sample    <= Dout;
              if (w_dwell_last) begin
                r_dwell_cnt <= '0;
                if (w_has_next) begin
                  r_state      <= S_SETTLE;
                  r_settle_cnt <= SET_W'(SETTLE - 1);
                  HopIdx       <= w_next_idx;
                  FCW          <= r_tbl_fcw[w_next_idx];
                end else begin
                  r_state <= S_DONE;
                  En      <= 1'b0;
                  Busy    <= 1'b0;
                  Done    <= 1'b1;
                end
              end else if (r_dwell_cnt != '1) begin
                r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_hop_ctrl.sv
// Scoreboard bench for nco_hop_ctrl: a sequence-level model predicts every
// cycle's control outputs and every forwarded sample; a monitor compares them.
module tb_nco_hop_ctrl;

  localparam int SETTLE  = 9;
  localparam int DWELL_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic               CfgWe = 1'b0;
  logic [1:0]         CfgAddr = '0;
  logic [19:0]        CfgFCW = '0;
  logic [DWELL_W-1:0] CfgDwell = '0;
  logic [1:0]         NumHops = '0;
  logic               Loop = 1'b0;
  logic               SelXYCfg = 1'b0;
  logic               SelSignCfg = 1'b0;
  logic               Start = 1'b0;
  logic               Stop = 1'b0;
  logic               Vld = 1'b0;
  logic [11:0]        Dout = '0;
  logic               En, selXY, selSign, SampleVld, Busy, Done, CfgErr;
  logic [19:0]        FCW;
  logic [11:0]        Sample;
  logic [1:0]         HopIdx;

  nco_hop_ctrl #(.SETTLE(SETTLE), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgFCW(CfgFCW),
    .CfgDwell(CfgDwell), .NumHops(NumHops), .Loop(Loop), .SelXYCfg(SelXYCfg),
    .SelSignCfg(SelSignCfg), .Start(Start), .Stop(Stop), .En(En), .FCW(FCW),
    .selXY(selXY), .selSign(selSign), .Vld(Vld), .Dout(Dout), .SampleVld(SampleVld),
    .Sample(Sample), .HopIdx(HopIdx), .Busy(Busy), .Done(Done), .CfgErr(CfgErr)
  );

  typedef struct packed {
    logic       en, busy, done, cfgerr, svld, xy, sign, known;
    logic [1:0] hop;
    logic [19:0] fcw;
  } ctl_t;

  ctl_t        ctl_q[$];
  logic [11:0] smp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sequence-level reference: phase, masked cycles left, samples taken on the hop.
  typedef enum {PH_IDLE, PH_MASK, PH_RUN, PH_DONE} phase_t;
  phase_t      m_ph;
  int          m_mask, m_cnt;
  logic [1:0]  m_hop;
  logic [19:0] m_fcw;
  logic        m_xy, m_sign, m_known;
  logic [19:0] m_tbl_fcw [4];
  logic [15:0] m_tbl_dw  [4];

  task automatic model_reset();
    m_ph = PH_IDLE; m_mask = 0; m_cnt = 0; m_hop = 2'd0; m_fcw = '0;
    m_xy = 1'b0; m_sign = 1'b0; m_known = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_tbl_fcw[i] = '0;
      m_tbl_dw[i]  = '0;
    end
  endtask

  task automatic enter_hop(input logic [1:0] idx);
    m_hop  = idx;
    m_fcw  = m_tbl_fcw[idx];
    m_mask = SETTLE;
    m_cnt  = 0;
    m_ph   = PH_MASK;
  endtask

  task automatic model_step();
    ctl_t e;
    bit   busy_now;
    int   dw;
    e = '0;
    busy_now = (m_ph == PH_MASK) || (m_ph == PH_RUN);
    e.cfgerr = CfgWe && busy_now;
    if (Stop) begin
      m_ph = PH_IDLE;
      m_known = 1'b0;
    end else begin
      case (m_ph)
        PH_IDLE: if (Start) begin
          m_xy = SelXYCfg; m_sign = SelSignCfg; m_known = 1'b1;
          enter_hop(2'd0);
        end
        PH_DONE: m_ph = PH_IDLE;
        PH_MASK: begin
          m_mask--;
          if (m_mask == 0) m_ph = PH_RUN;
        end
        PH_RUN: if (Vld) begin
          e.svld = 1'b1;
          smp_q.push_back(Dout);
          m_cnt++;
          dw = (m_tbl_dw[m_hop] == 16'd0) ? 1 : int'(m_tbl_dw[m_hop]);
          if (m_cnt >= dw) begin
            if (m_hop < NumHops) enter_hop(m_hop + 2'd1);
            else if (Loop) enter_hop(2'd0);
            else m_ph = PH_DONE;
          end
        end
        default: m_ph = PH_IDLE;
      endcase
    end
    if (CfgWe && !busy_now) begin
      m_tbl_fcw[CfgAddr] = CfgFCW;
      m_tbl_dw[CfgAddr]  = CfgDwell;
    end
    e.en    = (m_ph == PH_MASK) || (m_ph == PH_RUN);
    e.busy  = e.en;
    e.done  = (m_ph == PH_DONE);
    e.xy    = m_xy;
    e.sign  = m_sign;
    e.known = m_known;
    e.hop   = m_hop;
    e.fcw   = m_fcw;
    ctl_q.push_back(e);
  endtask

  ctl_t        mon_e;
  logic [11:0] mon_s;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (ctl_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ctl_underflow actual=output_cycle expected=none");
        end else begin
          mon_e = ctl_q.pop_front();
          chk("ctl_vec", 32'({En, Busy, Done, CfgErr, SampleVld, selXY, selSign}),
              32'({mon_e.en, mon_e.busy, mon_e.done, mon_e.cfgerr, mon_e.svld, mon_e.xy, mon_e.sign}));
          if (mon_e.known) chk("hop_fcw", {10'd0, HopIdx, FCW}, {10'd0, mon_e.hop, mon_e.fcw});
        end
        if (SampleVld) begin
          if (smp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sample_extra actual=%0h expected=no_sample", Sample);
          end else begin
            mon_s = smp_q.pop_front();
            chk("sample", 32'(Sample), 32'(mon_s));
          end
        end
      end
    end
  end

  task automatic tick();
    Dout = 12'($urandom);
    model_step();
    @(posedge clk);
    @(negedge clk);
    CfgWe = 1'b0; Start = 1'b0; Stop = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [19:0] f, input logic [15:0] d);
    CfgWe = 1'b1; CfgAddr = a; CfgFCW = f; CfgDwell = d;
    tick();
  endtask

  task automatic reset_outputs_zero(input string name);
    chk({name, "_fcw"}, 32'(FCW), 32'd0);
    chk({name, "_ctl"}, 32'({En, selXY, selSign, SampleVld, Sample, HopIdx, Busy, Done, CfgErr}), 32'd0);
  endtask

  int en_cnt, sv_cnt, dn_cnt, hop_changes;
  logic [1:0] prev_hop;

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_outputs_zero("rst_init");
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    tick();

    // Single entry, dwell 4, Vld held high
    cfg_write(2'd0, 20'h01000, 16'd4);
    NumHops = 2'd0; Loop = 1'b0; Vld = 1'b1; SelXYCfg = 1'b1; SelSignCfg = 1'b0;
    Start = 1'b1;
    en_cnt = 0; sv_cnt = 0; dn_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      en_cnt += int'(En); sv_cnt += int'(SampleVld); dn_cnt += int'(Done);
    end
    chk("single_en_cycles", 32'(en_cnt), 32'(SETTLE + 4));
    chk("single_samples", 32'(sv_cnt), 32'd4);
    chk("single_done", 32'(dn_cnt), 32'd1);
    chk("single_fcw_hold", 32'(FCW), 32'h01000);

    // Three looping entries, dwell 2
    cfg_write(2'd0, 20'h11111, 16'd2);
    cfg_write(2'd1, 20'h22222, 16'd2);
    cfg_write(2'd2, 20'h33333, 16'd2);
    NumHops = 2'd2; Loop = 1'b1; Vld = 1'b1; SelXYCfg = 1'b0; SelSignCfg = 1'b1;
    Start = 1'b1;
    tick();
    prev_hop = HopIdx; hop_changes = 0;
    for (int i = 0; i < 104; i++) begin
      tick();
      if (Busy && HopIdx != prev_hop) begin
        chk("loop_hop_seq", 32'(HopIdx), 32'((prev_hop + 2'd1) % 3));
        prev_hop = HopIdx;
        hop_changes++;
      end
    end
    chk("loop_hop_changes", 32'(hop_changes >= 6), 32'd1);
    Stop = 1'b1; tick();

    // Stop on the third RUN sample
    cfg_write(2'd0, 20'h0ABCD, 16'd10);
    NumHops = 2'd0; Loop = 1'b0; Vld = 1'b1;
    Start = 1'b1; tick();
    repeat (SETTLE + 2) tick();
    Stop = 1'b1; tick();
    chk("stop_en", 32'({En, Busy, SampleVld}), 32'd0);
    dn_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dn_cnt += int'(Done);
    end
    chk("stop_no_done", 32'(dn_cnt), 32'd0);
    Start = 1'b1; tick();
    chk("restart_hop", 32'({En, HopIdx}), 32'h4);
    Stop = 1'b1; tick();

    // Table write while busy is rejected
    Vld = 1'b0;
    Start = 1'b1; tick();
    tick();
    CfgWe = 1'b1; CfgAddr = 2'd0; CfgFCW = 20'hFFFFF; CfgDwell = 16'd1;
    tick();
    chk("cfgerr_pulse", 32'(CfgErr), 32'd1);
    tick();
    chk("cfgerr_clear", 32'(CfgErr), 32'd0);
    Stop = 1'b1; tick();
    Start = 1'b1; tick();
    chk("cfg_unchanged", 32'(FCW), 32'h0ABCD);
    Stop = 1'b1; tick();

    // Dwell 0 with Vld toggling
    cfg_write(2'd0, 20'h00100, 16'd0);
    cfg_write(2'd1, 20'h00200, 16'd0);
    NumHops = 2'd1; Loop = 1'b1; Vld = 1'b0;
    Start = 1'b1; tick();
    for (int i = 0; i < 60; i++) begin
      Vld = ~Vld;
      tick();
    end
    Stop = 1'b1; tick();

    // Asynchronous reset mid-RUN
    cfg_write(2'd0, 20'h54321, 16'd50);
    NumHops = 2'd0; Loop = 1'b0; Vld = 1'b1; SelXYCfg = 1'b1; SelSignCfg = 1'b1;
    Start = 1'b1; tick();
    repeat (SETTLE + 5) tick();
    chk("pre_reset_running", 32'({En, Busy}), 32'h3);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_outputs_zero("rst_async");
    @(posedge clk);
    #1;
    reset_outputs_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    ctl_q.delete();
    smp_q.delete();
    model_reset();
    mon_en = 1'b1;
    repeat (4) tick();
    Start = 1'b1; tick();
    chk("post_reset_fcw", 32'({En, FCW}), 32'h100000);
    Stop = 1'b1; tick();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        CfgWe = 1'b1;
        CfgAddr = 2'($urandom_range(0, 3));
        CfgFCW = 20'($urandom);
        CfgDwell = 16'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 49) == 0) begin
        NumHops = 2'($urandom_range(0, 3));
        Loop = 1'($urandom_range(0, 1));
      end
      Start = ($urandom_range(0, 7) == 0);
      Stop = ($urandom_range(0, 79) == 0);
      Vld = ($urandom_range(0, 2) != 0);
      SelXYCfg = 1'($urandom_range(0, 1));
      SelSignCfg = 1'($urandom_range(0, 1));
      tick();
    end
    Stop = 1'b1; tick();
    repeat (3) tick();

    chk("ctl_queue_empty", 32'(ctl_q.size()), 32'd0);
    chk("sample_queue_empty", 32'(smp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
